// File: rtl/serial_alu.sv
// Bit-serial ALU: add/sub/and/or/xor over WIDTH bits, one bit per clock, LSB first,
// through a single full adder and a carry flip-flop. All outputs are registered.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             b_bit, sum, cout, res_bit, capture, arith;
  logic [WIDTH-1:0] new_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      y_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    y_d     = y_q;
    carry_d = carry_q;
    zero_d  = zero_q;

    arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_bit   = (op_q == OP_SUB) ? ~b_sh_q[0] : b_sh_q[0];
    sum     = a_sh_q[0] ^ b_bit ^ cin_q;
    cout    = (a_sh_q[0] & b_bit) | (a_sh_q[0] & cin_q) | (b_bit & cin_q);

    case (op_q)
      OP_ADD, OP_SUB: res_bit = sum;
      OP_AND:         res_bit = a_sh_q[0] & b_sh_q[0];
      OP_OR:          res_bit = a_sh_q[0] | b_sh_q[0];
      OP_XOR:         res_bit = a_sh_q[0] ^ b_sh_q[0];
      default:        res_bit = 1'b0;
    endcase

    // Result bits enter the A shifter from the top; after WIDTH shifts it holds the result.
    new_y   = {res_bit, a_sh_q[WIDTH-1:1]};
    capture = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    case (state_q)
      S_IDLE, S_DONE: state_d = S_IDLE;
      S_RUN: begin
        a_sh_d = new_y;
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        cin_d  = cout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          y_d     = new_y;
          carry_d = arith ? cout : 1'b0;
          zero_d  = (new_y == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      a_sh_d  = a;
      b_sh_d  = b;
      op_d    = op;
      cnt_d   = '0;
      cin_d   = (op == OP_SUB);
      state_d = S_RUN;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign y     = y_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu at WIDTH=8.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         carry;
  logic         zero;

  int checks;
  int failures;
  int cyc;
  int n;
  int t1;
  int t2;
  int done_seen;
  logic [W-1:0] last_y;

  serial_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .carry (carry),
    .zero  (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from idle and check busy/done timing plus the final result.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] ey, input logic ec,
                       input logic ez, input logic mid_start);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk); #1;
    start = 1'b0;
    a     = ~av;
    b     = bv ^ 8'h5A;
    op    = 3'b111;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_done0"}, 32'(done), 32'd0);
    for (int k = 1; k < W; k++) begin
      if (mid_start && k == 3) begin
        start = 1'b1;
        a     = 8'hAA;
        op    = 3'b000;
      end
      if (mid_start && k == 4) start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_busyrun"}, 32'(busy), 32'd1);
      chk({tag, "_donerun"}, 32'(done), 32'd0);
      if (k == 4) chk({tag, "_yhold"}, 32'(y), 32'(last_y));
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busyd"}, 32'(busy), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    last_y = ey;
    @(posedge clk); #1;
    chk({tag, "_donepulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_noqueue"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    done_seen = 0;
    last_y    = '0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;

    @(posedge clk); #1;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_y",     32'(y),     32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero",  32'(zero),  32'd1);
    rst = 1'b0;

    do_op("add5a3c", 3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b0);
    do_op("addff01", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    do_op("sub0305", 3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
    do_op("sub1010", 3'b001, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
    do_op("and",     3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    do_op("or",      3'b011, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
    do_op("xor",     3'b100, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
    do_op("midstart",3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);

    // Back-to-back: start held high through DONE captures the second operation.
    start = 1'b1;
    op    = 3'b000;
    a     = 8'h11;
    b     = 8'h22;
    @(posedge clk); #1;
    a = 8'h40;
    b = 8'h02;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    t1 = cyc;
    chk("b2b_lat1", 32'(n), 32'd8);
    chk("b2b_y1", 32'(y), 32'h33);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy2", 32'(busy), 32'd1);
    chk("b2b_done2", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    t2 = cyc;
    chk("b2b_gap", 32'(t2 - t1), 32'd9);
    chk("b2b_y2", 32'(y), 32'h42);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    op    = 3'b000;
    a     = 8'h5A;
    b     = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_done",  32'(done),  32'd0);
    chk("arst_y",     32'(y),     32'd0);
    chk("arst_carry", 32'(carry), 32'd0);
    chk("arst_zero",  32'(zero),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = done_seen + 1;
    end
    chk("arst_nodone", 32'(done_seen), 32'd0);
    last_y = '0;

    do_op("invalid", 3'b111, 8'h5A, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request strobe; sampled on rising clk.
REQ-005 op  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101-111 invalid.
REQ-006 a  input  WIDTH  operand A; captured with accepted start.
REQ-007 b  input  WIDTH  operand B; captured with accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; y/carry/zero valid from this cycle.
REQ-010 y  output  WIDTH  registered result.
REQ-011 carry  output  1  carry-out (add); no-borrow flag (sub); 0 otherwise.
REQ-012 zero  output  1  high when y == 0.

Function
REQ-013 FSM states IDLE, RUN, DONE; all outputs registered; no combinational path from inputs to outputs.
REQ-014 IDLE: start=1 at an edge -> capture op, a, b; clear bit counter; go to RUN; busy=1 from the next cycle.
REQ-015 RUN: one bit per edge, LSB first, via a 1-bit full adder plus carry flip-flop; operand shift registers shift right each edge.
REQ-016 RUN lasts exactly WIDTH edges; the edge processing bit WIDTH-1 loads y, carry, zero; go to DONE; busy=0.
REQ-017 Latency: done is high in the cycle after WIDTH+1 edges counted from, and including, the capture edge.
REQ-018 DONE lasts one cycle; done=1; next edge -> IDLE, or -> RUN with new capture if start=1 (back-to-back, no idle gap).
REQ-019 start during RUN is ignored; captured operands are not disturbed; no request queued.
REQ-020 add: carry init 0; y = (a+b) mod 2^WIDTH; carry = bit WIDTH of a+b.
REQ-021 sub: per bit a + ~b, carry init 1; y = (a-b) mod 2^WIDTH; carry = 1 iff a >= b (unsigned).
REQ-022 and/or/xor: bitwise per bit; carry = 0.
REQ-023 Invalid op: same timing as valid ops; y = 0, carry = 0, zero = 1.
REQ-024 y, carry, zero hold their last value until the next DONE; they do not change during RUN.
REQ-025 Input changes on op/a/b after capture have no effect on the operation in progress.

Reset
REQ-026 rst=1 forces state IDLE immediately (no clock needed): busy=0, done=0, y=0, carry=0, zero=1, counter=0.
REQ-027 rst asserted mid-RUN aborts the operation; no done pulse is produced for it.
REQ-028 First rising edge after rst deasserts may accept start.

Verification (WIDTH=8)
REQ-029 op=000, a=8'h5A, b=8'h3C, start 1 cycle -> busy for 8 cycles, then done for 1 cycle, y=8'h96, carry=0, zero=0.
REQ-030 op=000, a=8'hFF, b=8'h01 -> y=8'h00, carry=1, zero=1; op=001, a=8'h03, b=8'h05 -> y=8'hFE, carry=0, zero=0.
REQ-031 op=001, a=8'h10, b=8'h10 -> y=8'h00, carry=1, zero=1; op=010/011/100, a=8'hF0, b=8'h3C -> y=8'h30 / 8'hFC / 8'hCC, carry=0.
REQ-032 start pulsed with a=8'h01, b=8'h01 (add), pulsed again mid-RUN with a=8'hAA -> single done, y=8'h02; operands changed after capture -> result unchanged.
REQ-033 start held high across DONE -> second operation captured at the DONE edge; done pulses exactly WIDTH+1 cycles apart.
REQ-034 rst asserted asynchronously at RUN bit 4 -> busy, done, y drop to 0 and zero=1 before the next edge; no done follows; op=111 -> y=0, zero=1, normal latency.
